// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory, with a bounded burst length
// and registered one-cycle read responses. Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | no beat accepted in the previous cycle
// OWN0   | port 0 accepted the previous beat
// OWN1   | port 1 accepted the previous beat
module dmem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p0_gnt,
    output logic             p1_gnt,
    output logic             p0_rvalid,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_out_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [3:0]       w_cnt_inc;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_win0;
    logic             w_win1;
    logic             w_acc0;
    logic             w_acc1;
    logic             r_p0_rvalid;
    logic             r_p1_rvalid;
    logic [WIDTH-1:0] r_p0_rdata;
    logic [WIDTH-1:0] r_p1_rdata;

    always_comb begin
        w_win0 = 1'b0;
        w_win1 = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w_win0 = p0_req;
        w_win1 = p1_req & ~p0_req;
`else
        if (r_state == S_OWN0 && p0_req && (r_cnt < BURST_LIM || !p1_req)) begin
            w_win0 = 1'b1;
        end else if (r_state == S_OWN1 && p1_req && (r_cnt < BURST_LIM || !p0_req)) begin
            w_win1 = 1'b1;
        end else if (p0_req && !p1_req) begin
            w_win0 = 1'b1;
        end else if (p1_req && !p0_req) begin
            w_win1 = 1'b1;
        end else if (p0_req && p1_req) begin
            // Contention out of a non-owning state: the port that did not win last time goes first.
            w_win0 = r_last;
            w_win1 = ~r_last;
        end
`endif
    end

    // Grants are forced low while reset is asserted so nothing reaches the memory.
    assign p0_gnt = w_win0 & rst_n;
    assign p1_gnt = w_win1 & rst_n;
    assign w_acc0 = p0_req & p0_gnt;
    assign w_acc1 = p1_req & p1_gnt;

    always_comb begin
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (w_acc0) begin
            mem_read_en    = ~p0_we;
            mem_write_en   = p0_we;
            mem_addr       = p0_addr;
            mem_write_data = p0_wdata;
        end else if (w_acc1) begin
            mem_read_en    = ~p1_we;
            mem_write_en   = p1_we;
            mem_addr       = p1_addr;
            mem_write_data = p1_wdata;
        end
    end

    // Count never wraps, even when fixed priority lets port 0 run past the burst limit.
    assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        if (w_acc0) begin
            if (r_state == S_OWN0) begin
                w_cnt_nxt = p1_req ? w_cnt_inc : BURST_LIM;
            end else begin
                w_state_nxt = S_OWN0;
                w_cnt_nxt   = 4'd1;
                w_last_nxt  = 1'b0;
            end
        end else if (w_acc1) begin
            if (r_state == S_OWN1) begin
                w_cnt_nxt = p0_req ? w_cnt_inc : BURST_LIM;
            end else begin
                w_state_nxt = S_OWN1;
                w_cnt_nxt   = 4'd1;
                w_last_nxt  = 1'b1;
            end
        end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_acc0 & ~p0_we;
            r_p1_rvalid <= w_acc1 & ~p1_we;
            if (w_acc0 && !p0_we) begin
                r_p0_rdata <= mem_out_data;
            end
            if (w_acc1 && !p1_we) begin
                r_p1_rdata <= mem_out_data;
            end
        end
    end

    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory block between the core load/store path (port 0) and a secondary requester such as a DMA or debug master (port 1). Each port uses a request/grant handshake. The arbiter drives the memory's read/write enables, address and write data from the winning port, and returns read data one cycle later through a registered response. Arbitration is round-robin with a bounded burst length, so neither port can starve the other.

## Interface
- `WIDTH`, 32, data and address width.
- `BURST_MAX`, 4, maximum consecutive beats an owner keeps while the other port is requesting. Range 1–15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  port requests a beat.
- `p0_we`, `p1_we`  in  1  beat is a write (1) or a read (0).
- `p0_addr`, `p1_addr`  in  WIDTH  beat address.
- `p0_wdata`, `p1_wdata`  in  WIDTH  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant. A beat is accepted when `req & gnt`.
- `p0_rvalid`, `p1_rvalid`  out  1  registered read response valid.
- `p0_rdata`, `p1_rdata`  out  WIDTH  registered read data.
- `mem_read_en`  out  1  memory read enable.
- `mem_write_en`  out  1  memory write enable.
- `mem_addr`  out  WIDTH  memory address.
- `mem_write_data`  out  WIDTH  memory write data.
- `mem_out_data`  in  WIDTH  combinational memory read data.

## Operation
- State registers:
  - `state`: IDLE, OWN0 or OWN1.
  - `cnt`: 4-bit beat count.
  - `last`: the most recent winner.
  - Per-port `rvalid` and `rdata`.
- The winner is computed combinationally every cycle:
  - If `state` is OWNx, `px_req`=1, and either `cnt`<`BURST_MAX` or the other port is idle, then x wins.
  - Otherwise, if exactly one port requests, that port wins.
  - Otherwise, if both ports request, the port that is not `last` wins.
  - Otherwise there is no winner.
- At most one `gnt` is high in any cycle. `gnt` may be high without a matching `req`; no beat is accepted in that case.
- On an accept by port x:
  - `mem_read_en` = !`px_we`, `mem_write_en` = `px_we`, `mem_addr` = `px_addr`, `mem_write_data` = `px_wdata`.
- With no accept, all `mem_*` outputs are 0.
- State transitions at the clock edge:
  - Accept by x while `state`=OWNx: `cnt` increments. If the other port is idle, `cnt` instead saturates at `BURST_MAX`.
  - Accept by x while `state`≠OWNx: `state` becomes OWNx, `cnt` becomes 1, `last` becomes x.
  - No accept: `state` becomes IDLE and `cnt` becomes 0.
- Read response: on a read accept by x, `px_rdata` captures `mem_out_data` and `px_rvalid` is high for exactly the next cycle.
- Write response: writes produce no `rvalid`; the write commits at the accept edge.
- Responses have no backpressure; the requester must consume `rvalid` in the cycle it is asserted.
- Reset mid-operation: all registers clear immediately and any pending read response is dropped.

## Timing
- Reset values: `state`=IDLE, `cnt`=0, `last`=1 (so port 0 wins the first contention).
- All outputs are 0 during reset, including both `gnt` when neither port requests.
- Grant latency: 0 cycles; a request is granted in the same cycle it is raised if that port wins.
- Read latency: 1 cycle from the accept edge to `rvalid`.
- Sustained throughput: 1 beat per clock.
- Back-to-back reads from alternating ports each receive `rvalid` exactly one cycle after their own accept.
- Burst boundary: after `BURST_MAX` accepted beats by x with y requesting, y wins the next cycle. x may regain the grant on the following cycle by the round-robin rule.
- Simultaneous first requests out of IDLE: the port that is not `last` wins.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - Port 0 wins every cycle it requests.
  - Port 1 wins only when `p0_req`=0.
  - `cnt` and `BURST_MAX` are ignored for port 0.
  - `last` is still updated.
- `DMEM_ARB_FIXED_PRIO_EN` undefined: round-robin with the burst limit, as described in Operation.

## Test plan
- Reset with `rst_n`=0 while `p0_req`=`p1_req`=1 → both `gnt`, all `mem_*` and both `rvalid` are 0. Release reset → `p0_gnt`=1 in the same cycle.
- Port 0 read with `addr`=0x10 and `mem_out_data`=0xDEADBEEF → `mem_read_en`=1 and `mem_addr`=0x10 in the accept cycle. Next cycle `p0_rvalid`=1 with `p0_rdata`=0xDEADBEEF, then `p0_rvalid`=0.
- Port 1 write with `addr`=0x24 and `wdata`=0xA5A5A5A5 → `mem_write_en`=1 for 1 cycle with that address and data. `p1_rvalid` stays 0.
- Both ports hold `req`=1 for 12 cycles with `BURST_MAX`=4 → grant sequence is P0×4, P1×4, P0×4.
- Read accepted, then `rst_n` pulsed low before the next edge → `p0_rvalid` never asserts and `state` returns to IDLE.
- With `DMEM_ARB_FIXED_PRIO_EN` defined and both requesting for 6 cycles → P0×6 and `p1_gnt`=0. Drop `p0_req` → `p1_gnt`=1 in the same cycle.
